// File: rtl/vend_pkg.sv
// Shared encodings for the vending panel arbiter: core service codes, items,
// coin codes/values, item costs and the arbiter state enum.
package vend_pkg;

  localparam logic [1:0] SERVICE_OFF  = 2'd0;
  localparam logic [1:0] SERVICE_ON   = 2'd1;
  localparam logic [1:0] SERVICE_BUSY = 2'd2;

  localparam logic [1:0] ITEM_NONE = 2'd0;
  localparam logic [1:0] ITEM_A    = 2'd1;
  localparam logic [1:0] ITEM_B    = 2'd2;
  localparam logic [1:0] ITEM_C    = 2'd3;

  localparam logic NTD_5 = 1'b1;
  localparam logic NTD_1 = 1'b0;

  localparam int unsigned COIN5_VALUE = 5;
  localparam int unsigned COIN1_VALUE = 1;

  localparam int unsigned COST_A = 8;
  localparam int unsigned COST_B = 15;
  localparam int unsigned COST_C = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_OFF,
    ST_REPORT,
    ST_ABORT
  } arb_state_e;

endpackage

// File: rtl/vend_rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after ptr, wrapping mod N.
module vend_rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    i_eligible,
  input  logic [IDXW-1:0] i_ptr,
  output logic [N-1:0]    o_winner,
  output logic [IDXW-1:0] o_winner_idx
);

  always_comb begin : pick
    logic        found;
    int unsigned j;
    o_winner     = '0;
    o_winner_idx = '0;
    found        = 1'b0;
    j            = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(i_ptr) + k) % N;
      if (!found && i_eligible[j]) begin
        found        = 1'b1;
        o_winner[j]  = 1'b1;
        o_winner_idx = IDXW'(j);
      end
    end
  end

endmodule

// File: rtl/vend_panel_arbiter.sv
// Shares one vending service core among N panels: round-robin issue, service
// tracking through BUSY/OFF, result return with done pulse, and a stall watchdog.
module vend_panel_arbiter
  import vend_pkg::*;
#(
  parameter int unsigned N              = 4,
  parameter int unsigned IDXW           = $clog2(N),
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [2*N-1:0] item_in,
  input  logic [N-1:0]   coin5_in,
  input  logic [N-1:0]   coin1_in,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic [1:0]     item_out,
  output logic [1:0]     coin5_out,
  output logic [1:0]     coin1_out,
  output logic           err,
  output logic [1:0]     core_item,
  output logic           core_coin5,
  output logic           core_coin1,
  output logic           core_rst_n,
  input  logic [1:0]     core_service,
  input  logic [1:0]     core_item_out,
  input  logic [1:0]     core_coin5_out,
  input  logic [1:0]     core_coin1_out
);

  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);
  // Abort decision taken one cycle early so ABORT lands TIMEOUT_CYCLES after ISSUE.
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 2);

  arb_state_e      r_state;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] r_idx;
  logic [WDW-1:0]  r_wd;
  logic [N-1:0]    r_grant;
  logic [N-1:0]    r_done;
  logic [1:0]      r_item_out;
  logic [1:0]      r_coin5_out;
  logic [1:0]      r_coin1_out;
  logic            r_err;
  logic [1:0]      r_core_item;
  logic            r_core_coin5;
  logic            r_core_coin1;
  logic            r_core_rst_n;

  logic [N-1:0]    w_eligible;
  logic [N-1:0]    w_win_onehot;
  logic [IDXW-1:0] w_win_idx;
  logic [IDXW-1:0] w_idx_next;

  always_comb begin
    w_eligible = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_eligible[i] = req[i] && (item_in[2*i +: 2] != ITEM_NONE);
    end
  end

  assign w_idx_next = (r_idx == IDXW'(N - 1)) ? '0 : r_idx + IDXW'(1);

  vend_rr_arbiter #(
    .N    (N),
    .IDXW (IDXW)
  ) u_rr (
    .i_eligible   (w_eligible),
    .i_ptr        (r_ptr),
    .o_winner     (w_win_onehot),
    .o_winner_idx (w_win_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_idx        <= '0;
      r_wd         <= '0;
      r_grant      <= '0;
      r_done       <= '0;
      r_item_out   <= ITEM_NONE;
      r_coin5_out  <= '0;
      r_coin1_out  <= '0;
      r_err        <= 1'b0;
      r_core_item  <= ITEM_NONE;
      r_core_coin5 <= 1'b0;
      r_core_coin1 <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      // Pulsed outputs default to idle; the core leaves reset one cycle after us.
      r_done       <= '0;
      r_err        <= 1'b0;
      r_core_item  <= ITEM_NONE;
      r_core_coin5 <= 1'b0;
      r_core_coin1 <= 1'b0;
      r_core_rst_n <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (core_service == SERVICE_ON && |w_eligible) begin
            r_idx        <= w_win_idx;
            r_grant      <= w_win_onehot;
            r_core_item  <= item_in[{w_win_idx, 1'b0} +: 2];
            r_core_coin5 <= coin5_in[w_win_idx];
            r_core_coin1 <= coin1_in[w_win_idx];
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_wd    <= '0;
          r_state <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY, ST_WAIT_OFF: begin
          if (r_wd == WD_LAST) begin
            r_err        <= 1'b1;
            r_core_rst_n <= 1'b0;
            r_state      <= ST_ABORT;
          end else begin
            r_wd <= r_wd + WDW'(1);
            if (r_state == ST_WAIT_BUSY && core_service == SERVICE_BUSY) begin
              r_state <= ST_WAIT_OFF;
            end else if (r_state == ST_WAIT_OFF && core_service == SERVICE_OFF) begin
              r_item_out  <= core_item_out;
              r_coin5_out <= core_coin5_out;
              r_coin1_out <= core_coin1_out;
              r_done      <= r_grant;
              r_state     <= ST_REPORT;
            end
          end
        end
        ST_REPORT, ST_ABORT: begin
          r_grant <= '0;
          r_ptr   <= w_idx_next;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign item_out   = r_item_out;
  assign coin5_out  = r_coin5_out;
  assign coin1_out  = r_coin1_out;
  assign err        = r_err;
  assign core_item  = r_core_item;
  assign core_coin5 = r_core_coin5;
  assign core_coin1 = r_core_coin1;
  assign core_rst_n = r_core_rst_n;

endmodule

// File: tb/tb_vend_panel_arbiter.sv
// Directed bench for vend_panel_arbiter: cycle vectors for single-panel, ineligible
// and core-not-ready flows, plus hand sequences for fairness, watchdog and mid-op reset.
module tb_vend_panel_arbiter;
  import vend_pkg::*;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [7:0]   item_in;
  logic [3:0]   coin5_in;
  logic [3:0]   coin1_in;
  logic [3:0]   grant;
  logic [3:0]   done;
  logic [1:0]   item_out;
  logic [1:0]   coin5_out;
  logic [1:0]   coin1_out;
  logic         err;
  logic [1:0]   core_item;
  logic         core_coin5;
  logic         core_coin1;
  logic         core_rst_n;
  logic [1:0]   core_service;
  logic [1:0]   core_item_out;
  logic [1:0]   core_coin5_out;
  logic [1:0]   core_coin1_out;

  int n_vec  = 0;
  int n_miss = 0;

  vend_panel_arbiter #(.N(N), .TIMEOUT_CYCLES(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .req            (req),
    .item_in        (item_in),
    .coin5_in       (coin5_in),
    .coin1_in       (coin1_in),
    .grant          (grant),
    .done           (done),
    .item_out       (item_out),
    .coin5_out      (coin5_out),
    .coin1_out      (coin1_out),
    .err            (err),
    .core_item      (core_item),
    .core_coin5     (core_coin5),
    .core_coin1     (core_coin1),
    .core_rst_n     (core_rst_n),
    .core_service   (core_service),
    .core_item_out  (core_item_out),
    .core_coin5_out (core_coin5_out),
    .core_coin1_out (core_coin1_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [7:0] item;
    logic [3:0] c5;
    logic [3:0] c1;
    logic [1:0] svc;
    logic [1:0] citem;
    logic [1:0] cc5;
    logic [1:0] cc1;
    logic [3:0] e_grant;
    logic [3:0] e_done;
    logic [1:0] e_core_item;
    logic       e_core_c5;
    logic       e_core_c1;
    logic [1:0] e_item;
    logic [1:0] e_c5;
    logic [1:0] e_c1;
  } vec_t;

  vec_t tbl[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input int k, input vec_t v);
    string t;
    n_vec++;
    t = $sformatf("vec%0d", k);
    chk({t, ".grant"},      8'(grant),      8'(v.e_grant));
    chk({t, ".done"},       8'(done),       8'(v.e_done));
    chk({t, ".core_item"},  8'(core_item),  8'(v.e_core_item));
    chk({t, ".core_coin5"}, 8'(core_coin5), 8'(v.e_core_c5));
    chk({t, ".core_coin1"}, 8'(core_coin1), 8'(v.e_core_c1));
    chk({t, ".err"},        8'(err),        8'h00);
    chk({t, ".core_rst_n"}, 8'(core_rst_n), 8'h01);
    chk({t, ".item_out"},   8'(item_out),   8'(v.e_item));
    chk({t, ".coin5_out"},  8'(coin5_out),  8'(v.e_c5));
    chk({t, ".coin1_out"},  8'(coin1_out),  8'(v.e_c1));
  endtask

  // One full transaction with all four panels requesting item B; coin1 change = ci.
  task automatic serve(input int idx, input logic [1:0] ci);
    logic [3:0] oh;
    logic [3:0] c5pat;
    string      t;
    oh    = 4'(1 << idx);
    c5pat = 4'b0101;
    t     = $sformatf("fair%0d", idx);
    core_service = SERVICE_ON;
    step();
    n_vec++;
    chk({t, ".grant"},      8'(grant),      8'(oh));
    chk({t, ".core_item"},  8'(core_item),  8'(ITEM_B));
    chk({t, ".core_coin5"}, 8'(core_coin5), 8'(c5pat[idx]));
    chk({t, ".core_coin1"}, 8'(core_coin1), 8'h01);
    step();
    core_service = SERVICE_BUSY;
    step();
    core_service   = SERVICE_OFF;
    core_item_out  = ITEM_B;
    core_coin5_out = 2'd0;
    core_coin1_out = ci;
    step();
    n_vec++;
    chk({t, ".done"},      8'(done),      8'(oh));
    chk({t, ".item_out"},  8'(item_out),  8'(ITEM_B));
    chk({t, ".coin1_out"}, 8'(coin1_out), 8'(ci));
    step();
    n_vec++;
    chk({t, ".done_clr"},  8'(done),  8'h00);
    chk({t, ".grant_clr"}, 8'(grant), 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no end, expected end of test");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    req            = '0;
    item_in        = '0;
    coin5_in       = '0;
    coin1_in       = '0;
    core_service   = SERVICE_OFF;
    core_item_out  = '0;
    core_coin5_out = '0;
    core_coin1_out = '0;

    // req, item, c5, c1, svc, citem, cc5, cc1 | grant, done, core_item, cc5, cc1, item_out, c5_out, c1_out
    tbl.push_back('{4'b0100, 8'h10, 4'b0100, 4'b0000, SERVICE_OFF,  2'd0, 2'd0, 2'd0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0});
    tbl.push_back('{4'b0100, 8'h10, 4'b0100, 4'b0000, SERVICE_ON,   2'd0, 2'd0, 2'd0, 4'b0100, 4'b0000, 2'd1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0});
    tbl.push_back('{4'b0100, 8'h10, 4'b0100, 4'b0000, SERVICE_ON,   2'd0, 2'd0, 2'd0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0});
    tbl.push_back('{4'b0100, 8'h10, 4'b0100, 4'b0000, SERVICE_BUSY, 2'd0, 2'd0, 2'd0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0});
    tbl.push_back('{4'b0100, 8'h10, 4'b0100, 4'b0000, SERVICE_BUSY, 2'd0, 2'd0, 2'd0, 4'b0100, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0});
    tbl.push_back('{4'b0100, 8'h10, 4'b0100, 4'b0000, SERVICE_OFF,  2'd1, 2'd0, 2'd2, 4'b0100, 4'b0100, 2'd0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd2});
    tbl.push_back('{4'b0000, 8'h00, 4'b0000, 4'b0000, SERVICE_OFF,  2'd0, 2'd0, 2'd0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd2});
    tbl.push_back('{4'b1010, 8'hC0, 4'b0000, 4'b1000, SERVICE_ON,   2'd0, 2'd0, 2'd0, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b1, 2'd1, 2'd0, 2'd2});
    tbl.push_back('{4'b1010, 8'hC0, 4'b0000, 4'b1000, SERVICE_ON,   2'd0, 2'd0, 2'd0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd2});
    tbl.push_back('{4'b1010, 8'hC0, 4'b0000, 4'b1000, SERVICE_BUSY, 2'd0, 2'd0, 2'd0, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd2});
    tbl.push_back('{4'b1010, 8'hC0, 4'b0000, 4'b1000, SERVICE_OFF,  2'd3, 2'd1, 2'd1, 4'b1000, 4'b1000, 2'd0, 1'b0, 1'b0, 2'd3, 2'd1, 2'd1});
    tbl.push_back('{4'b0010, 8'h00, 4'b0000, 4'b0000, SERVICE_OFF,  2'd0, 2'd0, 2'd0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd3, 2'd1, 2'd1});
    tbl.push_back('{4'b0010, 8'h00, 4'b0000, 4'b0000, SERVICE_ON,   2'd0, 2'd0, 2'd0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd3, 2'd1, 2'd1});
    tbl.push_back('{4'b0010, 8'h00, 4'b0000, 4'b0000, SERVICE_ON,   2'd0, 2'd0, 2'd0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd3, 2'd1, 2'd1});
    tbl.push_back('{4'b0001, 8'h01, 4'b0000, 4'b0001, SERVICE_BUSY, 2'd0, 2'd0, 2'd0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd3, 2'd1, 2'd1});
    tbl.push_back('{4'b0001, 8'h01, 4'b0000, 4'b0001, SERVICE_BUSY, 2'd0, 2'd0, 2'd0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd3, 2'd1, 2'd1});
    tbl.push_back('{4'b0001, 8'h01, 4'b0000, 4'b0001, SERVICE_OFF,  2'd0, 2'd0, 2'd0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd3, 2'd1, 2'd1});
    tbl.push_back('{4'b0001, 8'h01, 4'b0000, 4'b0001, SERVICE_ON,   2'd0, 2'd0, 2'd0, 4'b0001, 4'b0000, 2'd1, 1'b0, 1'b1, 2'd3, 2'd1, 2'd1});
    tbl.push_back('{4'b0001, 8'h01, 4'b0000, 4'b0001, SERVICE_ON,   2'd0, 2'd0, 2'd0, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd3, 2'd1, 2'd1});
    tbl.push_back('{4'b0001, 8'h01, 4'b0000, 4'b0001, SERVICE_BUSY, 2'd0, 2'd0, 2'd0, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd3, 2'd1, 2'd1});
    tbl.push_back('{4'b0001, 8'h01, 4'b0000, 4'b0001, SERVICE_OFF,  2'd1, 2'd0, 2'd0, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0});
    tbl.push_back('{4'b0000, 8'h00, 4'b0000, 4'b0000, SERVICE_OFF,  2'd0, 2'd0, 2'd0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0});

    // Reset state
    step();
    n_vec++;
    chk("rst.grant",      8'(grant),      8'h00);
    chk("rst.done",       8'(done),       8'h00);
    chk("rst.core_item",  8'(core_item),  8'(ITEM_NONE));
    chk("rst.core_rst_n", 8'(core_rst_n), 8'h00);
    chk("rst.err",        8'(err),        8'h00);
    chk("rst.item_out",   8'(item_out),   8'h00);
    reset = 1'b0;
    step();
    n_vec++;
    chk("rst_rel.core_rst_n", 8'(core_rst_n), 8'h01);
    chk("rst_rel.grant",      8'(grant),      8'h00);

    foreach (tbl[k]) begin
      req            = tbl[k].req;
      item_in        = tbl[k].item;
      coin5_in       = tbl[k].c5;
      coin1_in       = tbl[k].c1;
      core_service   = tbl[k].svc;
      core_item_out  = tbl[k].citem;
      core_coin5_out = tbl[k].cc5;
      core_coin1_out = tbl[k].cc1;
      step();
      chk_vec(k, tbl[k]);
    end

    // Fairness from ptr=0: all four panels held requesting B
    reset = 1'b1;
    step();
    reset    = 1'b0;
    req      = 4'b1111;
    item_in  = 8'hAA;
    coin5_in = 4'b0101;
    coin1_in = 4'b1111;
    core_service = SERVICE_OFF;
    step();
    serve(0, 2'd0);
    serve(1, 2'd1);
    serve(2, 2'd2);
    serve(3, 2'd3);
    serve(0, 2'd1);

    // Watchdog: ptr=1, core stuck in BUSY
    core_service = SERVICE_ON;
    step();
    n_vec++;
    chk("wd.issue_grant", 8'(grant),     8'h02);
    chk("wd.issue_item",  8'(core_item), 8'(ITEM_B));
    core_service = SERVICE_BUSY;
    for (int c = 1; c <= 15; c++) begin
      step();
      n_vec++;
      chk($sformatf("wd.c%0d.err", c),  8'(err),  8'h00);
      chk($sformatf("wd.c%0d.done", c), 8'(done), 8'h00);
    end
    step();
    n_vec++;
    chk("wd.c16.err",        8'(err),        8'h01);
    chk("wd.c16.core_rst_n", 8'(core_rst_n), 8'h00);
    chk("wd.c16.done",       8'(done),       8'h00);
    step();
    n_vec++;
    chk("wd.after.err",        8'(err),        8'h00);
    chk("wd.after.core_rst_n", 8'(core_rst_n), 8'h01);
    chk("wd.after.grant",      8'(grant),      8'h00);
    chk("wd.after.done",       8'(done),       8'h00);
    core_service = SERVICE_ON;
    step();
    n_vec++;
    chk("wd.next_grant", 8'(grant), 8'h04);

    // Mid-operation reset while waiting for OFF
    step();
    core_service = SERVICE_BUSY;
    step();
    step();
    n_vec++;
    chk("mid.pre.grant", 8'(grant), 8'h04);
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    chk("mid.async.grant",      8'(grant),      8'h00);
    chk("mid.async.core_rst_n", 8'(core_rst_n), 8'h00);
    chk("mid.async.item_out",   8'(item_out),   8'h00);
    chk("mid.async.coin1_out",  8'(coin1_out),  8'h00);
    chk("mid.async.core_item",  8'(core_item),  8'h00);
    core_service   = SERVICE_OFF;
    core_item_out  = ITEM_B;
    core_coin1_out = 2'd3;
    for (int c = 0; c < 2; c++) begin
      step();
      n_vec++;
      chk($sformatf("mid.hold%0d.done", c),       8'(done),       8'h00);
      chk($sformatf("mid.hold%0d.err", c),        8'(err),        8'h00);
      chk($sformatf("mid.hold%0d.core_rst_n", c), 8'(core_rst_n), 8'h00);
    end
    reset = 1'b0;
    step();
    n_vec++;
    chk("mid.rel.core_rst_n", 8'(core_rst_n), 8'h01);
    chk("mid.rel.done",       8'(done),       8'h00);
    chk("mid.rel.grant",      8'(grant),      8'h00);
    chk("mid.rel.item_out",   8'(item_out),   8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
